// File: rtl/dma_ahb_master.sv
// dma_ahb_master: AHB-Lite burst engine of the DMA.
// Executes one INCR burst per arbiter request. Reads move bus data into the
// stream FIFO; writes drain the show-ahead FIFO onto the bus. Address and
// data phases are overlapped. An ERROR response aborts the burst cleanly.
module dma_ahb_master #(
  parameter int addr_w = 32,
  parameter int data_w = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_master_en,
  input  logic              i_req,
  input  logic [addr_w-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_burst,
  input  logic              i_write,
  input  logic [data_w-1:0] i_fifo_rdata,
  output logic              o_fifo_rd,
  output logic              o_fifo_wr,
  output logic [data_w-1:0] o_fifo_wdata,
  output logic [addr_w-1:0] o_haddr,
  output logic [1:0]        o_htrans,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize,
  output logic [2:0]        o_hburst,
  output logic [data_w-1:0] o_hwdata,
  input  logic              i_hready,
  input  logic              i_hresp,
  input  logic [data_w-1:0] i_hrdata,
  output logic              o_master_ready,
  output logic              o_burst_done,
  output logic              o_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_LAST = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  state_t            state_reg;
  logic [4:0]        beats_reg;      // address phases still to be issued
  logic [1:0]        size_reg;       // normalised transfer size of the burst
  logic [addr_w-1:0] haddr_reg;
  logic [1:0]        htrans_reg;
  logic              hwrite_reg;
  logic [2:0]        hsize_reg;
  logic [2:0]        hburst_reg;
  logic [data_w-1:0] hwdata_reg;
  logic              dphase_reg;     // a beat is in its data phase this cycle
  logic              master_ready_reg;
  logic              burst_done_reg;
  logic              error_reg;

  logic [1:0]        req_size;
  logic [4:0]        req_beats;
  logic [2:0]        req_hburst;
  logic [addr_w-1:0] req_last_addr;
  logic [addr_w-1:0] addr_incr;
  logic              err_cycle;
  logic              abort;
  logic              addr_accept;

  // Decode the arbiter's request: size 3 behaves as word, burst code to beat count.
  always_comb begin
    req_size   = (i_size == 2'd3) ? 2'd2 : i_size;
    req_beats  = 5'd1;
    req_hburst = 3'd0;
    case (i_burst)
      2'd0: begin req_beats = 5'd1;  req_hburst = 3'd0; end
      2'd1: begin req_beats = 5'd4;  req_hburst = 3'd3; end
      2'd2: begin req_beats = 5'd8;  req_hburst = 3'd5; end
      default: begin req_beats = 5'd16; req_hburst = 3'd7; end
    endcase
  end

  assign req_last_addr = i_addr + ({{(addr_w-5){1'b0}}, req_beats - 5'd1} << req_size);
  assign addr_incr     = {{(addr_w-1){1'b0}}, 1'b1} << size_reg;

  // An ERROR response occupies two cycles; the pending address is cancelled in
  // both, so it can never be accepted by the slave.
  assign err_cycle   = dphase_reg & i_hresp;
  assign abort       = err_cycle & i_hready;
  assign addr_accept = htrans_reg[1] & i_hready & ~err_cycle;

  assign o_htrans       = err_cycle ? TRANS_IDLE : htrans_reg;
  assign o_haddr        = haddr_reg;
  assign o_hwrite       = hwrite_reg;
  assign o_hsize        = hsize_reg;
  assign o_hburst       = hburst_reg;
  assign o_hwdata       = hwdata_reg;
  assign o_master_ready = master_ready_reg;
  assign o_burst_done   = burst_done_reg;
  assign o_error        = error_reg;

  // FIFO strobes are tied to the bus handshake, so wait states issue none.
  assign o_fifo_rd    = addr_accept & hwrite_reg;
  assign o_fifo_wr    = dphase_reg & ~hwrite_reg & i_hready & ~i_hresp;
  assign o_fifo_wdata = i_hrdata;

  // Burst FSM with registered bus controls and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= ST_IDLE;
      beats_reg        <= 5'd0;
      size_reg         <= 2'd0;
      haddr_reg        <= '0;
      htrans_reg       <= TRANS_IDLE;
      hwrite_reg       <= 1'b0;
      hsize_reg        <= 3'd0;
      hburst_reg       <= 3'd0;
      hwdata_reg       <= '0;
      dphase_reg       <= 1'b0;
      master_ready_reg <= 1'b1;
      burst_done_reg   <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      burst_done_reg <= 1'b0;
      error_reg      <= 1'b0;

      // A data phase follows every accepted address; it only moves on hready.
      if (i_hready) begin
        dphase_reg <= addr_accept;
      end

      // Capture the FIFO head as the address is accepted; it then stays
      // stable for that beat's whole data phase, including wait states.
      if (addr_accept && hwrite_reg) begin
        hwdata_reg <= i_fifo_rdata;
      end

      case (state_reg)
        ST_IDLE: begin
          master_ready_reg <= 1'b1;
          if (i_master_en && i_req) begin
            haddr_reg        <= i_addr;
            htrans_reg       <= TRANS_NONSEQ;
            hwrite_reg       <= i_write;
            hsize_reg        <= {1'b0, req_size};
            hburst_reg       <= req_hburst;
            size_reg         <= req_size;
            beats_reg        <= req_beats;
            master_ready_reg <= 1'b0;
            state_reg        <= ST_ADDR;
          end
        end

        ST_ADDR, ST_DATA: begin
          if (abort) begin
            htrans_reg       <= TRANS_IDLE;
            error_reg        <= 1'b1;
            master_ready_reg <= 1'b1;
            state_reg        <= ST_IDLE;
          end else if (addr_accept) begin
            beats_reg <= beats_reg - 5'd1;
            if (beats_reg == 5'd1) begin
              htrans_reg <= TRANS_IDLE;
              state_reg  <= ST_LAST;
            end else begin
              haddr_reg  <= haddr_reg + addr_incr;
              htrans_reg <= TRANS_SEQ;
              state_reg  <= ST_DATA;
            end
          end
        end

        ST_LAST: begin
          if (abort) begin
            error_reg        <= 1'b1;
            master_ready_reg <= 1'b1;
            state_reg        <= ST_IDLE;
          end else if (i_hready) begin
            burst_done_reg   <= 1'b1;
            master_ready_reg <= 1'b1;
            state_reg        <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Simulation-only guard: stream programming must keep each burst inside one 1 KB page.
  always_ff @(posedge i_clk) begin
    if (!i_reset && state_reg == ST_IDLE && i_master_en && i_req) begin
      assert (i_addr[addr_w-1:10] == req_last_addr[addr_w-1:10]);
    end
  end

endmodule

// File: tb/tb_dma_ahb_master.sv
// tb_dma_ahb_master: directed bursts against a small AHB slave model, with
// scoreboards for expected addresses, FIFO pushes and write data.
module tb_dma_ahb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, master_en, req, write;
  logic [AW-1:0] addr;
  logic [1:0]    size, burst;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd, fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize, hburst;
  logic [DW-1:0] hwdata;
  logic          hready, hresp;
  logic [DW-1:0] hrdata;
  logic          master_ready, burst_done, error;

  dma_ahb_master #(.addr_w(AW), .data_w(DW)) dut (
    .i_clk(clk), .i_reset(reset), .i_master_en(master_en), .i_req(req),
    .i_addr(addr), .i_size(size), .i_burst(burst), .i_write(write),
    .i_fifo_rdata(fifo_rdata), .o_fifo_rd(fifo_rd), .o_fifo_wr(fifo_wr),
    .o_fifo_wdata(fifo_wdata), .o_haddr(haddr), .o_htrans(htrans),
    .o_hwrite(hwrite), .o_hsize(hsize), .o_hburst(hburst), .o_hwdata(hwdata),
    .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata),
    .o_master_ready(master_ready), .o_burst_done(burst_done), .o_error(error)
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
  } addr_exp_t;

  addr_exp_t   exp_addr_q[$];
  logic [31:0] exp_push_q[$];
  logic [31:0] exp_hwdata_q[$];
  logic [31:0] fifo_q[$];

  int tests = 0;
  int fails = 0;
  int dbeat, beat_ctr, cyc, burst_id;
  int n_rd, n_wr, n_done, n_err, done_cyc;
  logic done_ready;
  int wait_beat, wait_len, wait_cnt, err_beat, err_cnt;
  logic       exp_hwrite;
  logic [2:0] exp_hsize, exp_hburst;
  int d_base, e_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_pattern(input int k);
    return 32'hC0DE_0000 + 32'(burst_id << 8) + 32'(k);
  endfunction

  // One bus cycle: drive slave response at posedge+1, observe at negedge.
  task automatic bus_cycle();
    int next_dbeat;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (dbeat >= 0) begin
      if (dbeat == err_beat) begin
        hresp  = 1'b1;
        hready = (err_cnt > 0);
        err_cnt++;
      end else if (dbeat == wait_beat && wait_cnt < wait_len) begin
        hready = 1'b0;
        wait_cnt++;
      end else if (!exp_hwrite) begin
        hrdata = rd_pattern(dbeat);
      end
    end
    fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    @(negedge clk);
    next_dbeat = dbeat;
    n_rd   += int'(fifo_rd);
    n_wr   += int'(fifo_wr);
    n_done += int'(burst_done);
    n_err  += int'(error);
    if (burst_done) begin
      done_cyc   = cyc;
      done_ready = master_ready;
    end
    if (hresp) check("htrans_idle_on_error", htrans, 2'd0);
    if (!hready) begin
      check("no_fifo_rd_in_wait", fifo_rd, 1'b0);
      check("no_fifo_wr_in_wait", fifo_wr, 1'b0);
    end
    // data phase side
    if (dbeat >= 0) begin
      if (exp_hwrite && exp_hwdata_q.size() > 0) check("hwdata", hwdata, exp_hwdata_q[0]);
      if (hready) begin
        next_dbeat = -1;
        if (hresp) begin
          if (!exp_hwrite) check("no_push_on_error", fifo_wr, 1'b0);
        end else if (exp_hwrite) begin
          if (exp_hwdata_q.size() > 0) void'(exp_hwdata_q.pop_front());
        end else begin
          check("fifo_wr", fifo_wr, 1'b1);
          if (exp_push_q.size() > 0) check("fifo_wdata", fifo_wdata, exp_push_q.pop_front());
          else check("fifo_wr_unexpected", fifo_wr, 1'b0);
        end
      end
    end else begin
      check("no_push_idle", fifo_wr, 1'b0);
    end
    // address phase side
    if (htrans[1]) begin
      if (exp_addr_q.size() == 0) begin
        check("htrans_unexpected", htrans, 2'd0);
      end else begin
        check("haddr", haddr, exp_addr_q[0].a);
        check("htrans", htrans, exp_addr_q[0].t);
        check("hwrite", hwrite, exp_hwrite);
        check("hsize", hsize, exp_hsize);
        check("hburst", hburst, exp_hburst);
        if (hready) begin
          check("fifo_rd", fifo_rd, exp_hwrite);
          if (exp_hwrite) begin
            exp_hwdata_q.push_back((fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF);
            if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
          end
          void'(exp_addr_q.pop_front());
          next_dbeat = beat_ctr;
          beat_ctr++;
        end
      end
    end else if (hready) begin
      check("no_fifo_rd_idle", fifo_rd, 1'b0);
    end
    @(posedge clk);
    #1;
    dbeat = next_dbeat;
    cyc++;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] bu,
                           input logic wr, input logic [31:0] wbase,
                           input int wbeat, input int wlen, input int ebeat,
                           input bit drop_en, input int reset_at, input int exp_lat);
    int beats, szn, d0, e0, rd0, wr0, guard, req_cyc, pushes;
    bit did_reset;
    beats = (bu == 2'd0) ? 1 : (bu == 2'd1) ? 4 : (bu == 2'd2) ? 8 : 16;
    szn   = (sz == 2'd3) ? 2 : int'(sz);
    burst_id++;
    for (int k = 0; k < beats; k++) begin
      addr_exp_t e;
      e.a = a + 32'(k << szn);
      e.t = (k == 0) ? 2'd2 : 2'd3;
      exp_addr_q.push_back(e);
    end
    pushes = (ebeat >= 0) ? ebeat : beats;
    if (!wr) begin
      for (int k = 0; k < pushes; k++) exp_push_q.push_back(rd_pattern(k));
    end else begin
      for (int k = 0; k < beats; k++) fifo_q.push_back(wbase + 32'(k));
    end
    exp_hwrite = wr;
    exp_hsize  = {1'b0, 2'(szn)};
    exp_hburst = (bu == 2'd0) ? 3'd0 : {bu, 1'b1};
    wait_beat = wbeat; wait_len = wlen; wait_cnt = 0;
    err_beat = ebeat; err_cnt = 0; beat_ctr = 0;
    d0 = n_done; e0 = n_err; rd0 = n_rd; wr0 = n_wr; did_reset = 0;

    master_en = 1'b1; addr = a; size = sz; burst = bu; write = wr; req = 1'b1;
    check("master_ready_before_accept", master_ready, 1'b1);
    req_cyc = cyc;
    bus_cycle();
    req = 1'b0;
    if (drop_en) master_en = 1'b0;
    check("master_ready_after_accept", master_ready, 1'b0);

    guard = 0;
    while (n_done == d0 && n_err == e0 && guard < 200) begin
      if (guard == reset_at) begin
        reset = 1'b1;
        bus_cycle();
        reset = 1'b0;
        did_reset = 1;
        exp_addr_q.delete(); exp_push_q.delete(); exp_hwdata_q.delete(); fifo_q.delete();
        dbeat = -1;
        check("reset_htrans_idle", htrans, 2'd0);
        check("reset_master_ready", master_ready, 1'b1);
        check("reset_no_done", burst_done, 1'b0);
        check("reset_no_error", error, 1'b0);
        break;
      end
      bus_cycle();
      guard++;
    end

    if (!did_reset) begin
      tests++;
      assert (guard < 200) else begin
        fails++;
        $error("FAIL burst_timeout observed=%0d cycles expected<200", guard);
      end
      check("burst_done_count", n_done - d0, (ebeat < 0) ? 1 : 0);
      check("error_count", n_err - e0, (ebeat < 0) ? 0 : 1);
      check("fifo_rd_count", n_rd - rd0, wr ? beats : 0);
      check("fifo_wr_count", n_wr - wr0, wr ? 0 : pushes);
      check("push_queue_drained", exp_push_q.size(), 0);
      if (ebeat < 0) check("ready_with_done", done_ready, 1'b1);
      if (exp_lat >= 0) check("done_latency", done_cyc - req_cyc - 1, exp_lat);
      exp_addr_q.delete(); exp_hwdata_q.delete(); fifo_q.delete();
      dbeat = -1;
    end
  endtask

  initial begin
    reset = 1'b1; master_en = 1'b0; req = 1'b0; addr = '0; size = '0; burst = '0;
    write = 1'b0; fifo_rdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    dbeat = -1; beat_ctr = 0; cyc = 0; burst_id = 0;
    n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; done_cyc = 0; done_ready = 1'b0;
    wait_beat = -1; wait_len = 0; wait_cnt = 0; err_beat = -1; err_cnt = 0;
    exp_hwrite = 1'b0; exp_hsize = 3'd0; exp_hburst = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_htrans", htrans, 2'd0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", hwrite, 1'b0);
    check("rst_hsize", hsize, 3'd0);
    check("rst_hburst", hburst, 3'd0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_fifo_wr", fifo_wr, 1'b0);
    check("rst_done", burst_done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_master_ready", master_ready, 1'b1);
    @(posedge clk);
    #1;
    cyc++;

    // inc4 word read at 0x100, zero wait states
    run_burst(32'h100, 2'd2, 2'd1, 1'b0, 32'h0, -1, 0, -1, 1'b0, -1, 5);
    bus_cycle();
    // single byte write to 0x3, FIFO head 0xAB
    run_burst(32'h3, 2'd0, 2'd0, 1'b1, 32'hAB, -1, 0, -1, 1'b0, -1, 2);
    bus_cycle();
    // inc8 hword write at 0x200, two wait states on beat 3
    run_burst(32'h200, 2'd1, 2'd2, 1'b1, 32'h5500, 2, 2, -1, 1'b0, -1, -1);
    bus_cycle();
    // inc16 word read at 0x400, ERROR on beat 5
    run_burst(32'h400, 2'd2, 2'd3, 1'b0, 32'h0, -1, 0, 4, 1'b0, -1, -1);
    bus_cycle();
    // illegal size 3 behaves as word
    run_burst(32'h500, 2'd3, 2'd1, 1'b0, 32'h0, -1, 0, -1, 1'b0, -1, 5);
    bus_cycle();
    // enable dropped mid-burst: burst still completes
    run_burst(32'h300, 2'd2, 2'd1, 1'b0, 32'h0, -1, 0, -1, 1'b1, -1, 5);
    bus_cycle();
    // reset in the middle of a burst: abandoned without pulses
    run_burst(32'h340, 2'd2, 2'd1, 1'b0, 32'h0, -1, 0, -1, 1'b0, 2, -1);
    d_base = n_done;
    e_base = n_err;
    repeat (3) bus_cycle();
    check("post_reset_no_done", n_done - d_base, 0);
    check("post_reset_no_error", n_err - e_base, 0);
    check("post_reset_ready", master_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_ahb_master.md
Name: dma_ahb_master

Overview:
- AHB-Lite master engine of the DMA; sits downstream of the stream arbiter.
- The arbiter supplies the selected stream's transfer parameters and an enable. This block executes exactly one burst per request and hands control back through o_master_ready, which the arbiter samples to swap streams.
- On reads it moves bus data into the stream FIFO; on writes it drains the FIFO onto the bus.

Parameters:
- addr_w, 32, AHB address width.
- data_w, 32, AHB data width; transfer sizes up to word.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_master_en  in  1  arbiter grant; high while the arbiter is in its work state.
- i_req  in  1  the selected stream wants one burst.
- i_addr  in  addr_w  start address of the burst.
- i_size  in  2  0 = byte, 1 = hword, 2 = word; 3 is illegal and treated as word.
- i_burst  in  2  0 = single (1 beat), 1 = inc4, 2 = inc8, 3 = inc16.
- i_write  in  1  1 = bus write (FIFO to bus), 0 = bus read (bus to FIFO).
- i_fifo_rdata  in  data_w  show-ahead FIFO head, valid for writes.
- o_fifo_rd  out  1  pop FIFO head.
- o_fifo_wr  out  1  push o_fifo_wdata.
- o_fifo_wdata  out  data_w  read data to the FIFO.
- o_haddr  out  addr_w  AHB address.
- o_htrans  out  2  AHB trans: 0 = IDLE, 2 = NONSEQ, 3 = SEQ.
- o_hwrite  out  1  AHB direction.
- o_hsize  out  3  AHB size, zero-extended from i_size.
- o_hburst  out  3  single → 0, inc4 → 3, inc8 → 5, inc16 → 7.
- o_hwdata  out  data_w  AHB write data.
- i_hready  in  1  AHB ready.
- i_hresp  in  1  AHB error response.
- i_hrdata  in  data_w  AHB read data.
- o_master_ready  out  1  engine idle; arbiter may swap streams.
- o_burst_done  out  1  one-cycle pulse when a burst completes without error.
- o_error  out  1  one-cycle pulse when a burst is aborted on i_hresp.

Behaviour:
- Reset values:
  - htrans = 0; haddr, hwrite, hsize, hburst, hwdata all 0.
  - o_fifo_rd, o_fifo_wr, o_burst_done, o_error = 0.
  - o_master_ready = 1.
  - FSM in ST_IDLE, all counters 0.
- Reset mid-burst: the next cycle htrans = IDLE and the FSM is in ST_IDLE. The burst is abandoned, with no done or error pulse.
- FSM states: ST_IDLE, ST_ADDR, ST_DATA, ST_LAST.
- ST_IDLE:
  - o_master_ready = 1.
  - On i_master_en & i_req: latch addr, size, burst and write; load the beat counter with 1/4/8/16. Go to ST_ADDR.
  - o_master_ready drops in the same cycle the request is accepted (registered, visible next cycle).
- ST_ADDR:
  - Drives the first address phase: htrans = NONSEQ, haddr = latched address.
  - Advances when i_hready = 1. Go to ST_LAST if beats = 1, else ST_DATA.
- ST_DATA (overlapped pipeline):
  - Drives the next address with htrans = SEQ; the previous beat is in its data phase.
  - Address increment is 1 << size.
  - Each i_hready = 1 completes one data phase and issues the next address.
  - When the last address has been accepted, go to ST_LAST.
- ST_LAST:
  - htrans = IDLE; the final data phase is pending.
  - On i_hready = 1: pulse o_burst_done and return to ST_IDLE.
- Per-burst timing: minimum latency from request accept to o_burst_done is beats + 1 cycles with zero wait states. There is one idle cycle between consecutive bursts.
- Wait states: while i_hready = 0, haddr, htrans, hwdata and all control outputs hold. No FIFO strobes are issued.
- Write data path:
  - o_hwdata is registered from i_fifo_rdata when the corresponding address phase is accepted, so it is valid throughout that beat's data phase.
  - o_fifo_rd pulses once per accepted write address phase.
- Read data path: o_fifo_wr = data phase active & !hwrite & i_hready & !i_hresp, with o_fifo_wdata = i_hrdata.
- Error response (i_hresp = 1 in a data phase):
  - First cycle (i_hready = 0): force htrans = IDLE and issue no further addresses.
  - Second cycle (i_hready = 1): pulse o_error and go to ST_IDLE.
  - The beat in error is never pushed to the FIFO.
- i_master_en deassertion mid-burst does not abort the burst: AHB bursts complete. The enable is only sampled in ST_IDLE.
- Address boundary:
  - Address arithmetic wraps modulo 2^addr_w.
  - Bursts must not cross a 1 KB boundary; the stream programming guarantees this.
  - The master does not split bursts. Crossing is flagged by assertion in simulation only.

Test Plan:
- Reset, then i_master_en = 1, i_req = 1, addr 0x100, word, inc4, read, hready always 1 → haddr 0x100/0x104/0x108/0x10C; htrans 2,3,3,3 then 0; 4 o_fifo_wr pulses; o_burst_done 5 cycles after accept.
- Single byte write to 0x3, FIFO head 0xAB → one NONSEQ with hsize 0, hburst 0; o_hwdata = 0xAB in the data phase; one o_fifo_rd pulse; then o_master_ready = 1.
- inc8 hword write to 0x200, hready low for 2 cycles on beat 3 → address 0x206 and hwdata held for 2 cycles; 8 o_fifo_rd pulses total; addresses step by 2.
- inc16 read with i_hresp on beat 5 (two-cycle error response) → htrans = IDLE from the first error cycle; exactly 4 o_fifo_wr pulses; o_error pulses once; no o_burst_done.
- i_master_en dropped during an inc4 burst, then synchronous i_reset asserted during a second burst → the first burst completes normally; after the reset cycle htrans = 0 and o_master_ready = 1, with no pulses.
